// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS instruction-fetch front end.
package mips_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;

  localparam logic [ADDR_W-1:0]  PC_STEP          = 32'd4;
  localparam logic [ADDR_W-1:0]  RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [INSTR_W-1:0] NOP              = 32'h0000_0000;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead FIFO with flush: head entry is visible on head_data whenever count != 0.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  // Flush wins over both push and pop issued in the same cycle.
  always_comb begin
    do_push  = push && !flush;
    do_pop   = pop && !flush && (count_q != '0);
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + {{PTR_W{1'b0}}, do_push} - {{PTR_W{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        mem_q[gi] <= '0;
      end else if (do_push && (wr_ptr_q == PTR_W'(gi))) begin
        mem_q[gi] <= push_data;
      end
    end
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;

endmodule

// File: rtl/if_prefetch_queue.sv
// Instruction prefetcher: issues sequential reads to a 1-cycle synchronous RAM and
// queues {pc, instr} pairs; a redirect flushes the queue and restarts at the new pc.
module if_prefetch_queue
  import mips_pkg::*;
#(
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_en,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               instr_ready
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
  logic              inflight_q, inflight_d;
  logic              drop_q, drop_d;
  logic [CNT_W-1:0]  count;
  logic [CNT_W:0]    credit_used;
  logic              pop, push, issue;
  fetch_entry_t      push_entry, head_entry;

  assign pop = instr_valid && instr_ready;

  // inflight_q marks that imem_rdata this cycle belongs to inflight_pc_q.
  always_comb begin
    credit_used = {1'b0, count} + (CNT_W+1)'(inflight_q) - (CNT_W+1)'(pop);
    issue       = !rst && !redirect_valid && (credit_used < (CNT_W+1)'(DEPTH));
    push        = inflight_q && !drop_q;
    push_entry  = '{pc: inflight_pc_q, instr: imem_rdata};

    fetch_pc_d    = fetch_pc_q;
    inflight_d    = issue;
    inflight_pc_d = issue ? fetch_pc_q : inflight_pc_q;
    drop_d        = redirect_valid ? inflight_q : 1'b0;
    if (redirect_valid) begin
      fetch_pc_d = word_align(redirect_pc);
    end else if (issue) begin
      fetch_pc_d = fetch_pc_q + PC_STEP;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      inflight_pc_q <= '0;
      inflight_q    <= 1'b0;
      drop_q        <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_pc_q <= inflight_pc_d;
      inflight_q    <= inflight_d;
      drop_q        <= drop_d;
    end
  end

  sync_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head_data (head_entry),
    .count     (count)
  );

  assign imem_en     = issue;
  assign imem_addr   = fetch_pc_q;
  assign instr_valid = (count != '0);
  assign instr       = head_entry.instr;
  assign instr_pc    = head_entry.pc;

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Directed bench for if_prefetch_queue; RAM model returns word index (addr>>2) one cycle after a read.
module tb_if_prefetch_queue;
  import mips_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        a_en, a_redir, a_valid, a_ready;
  logic [31:0] a_addr, a_rdata, a_redir_pc, a_instr, a_pc;
  logic        b_en, b_redir, b_valid, b_ready;
  logic [31:0] b_addr, b_rdata, b_redir_pc, b_instr, b_pc;

  if_prefetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut_a (
    .clk(clk), .rst(rst), .imem_en(a_en), .imem_addr(a_addr), .imem_rdata(a_rdata),
    .redirect_valid(a_redir), .redirect_pc(a_redir_pc), .instr_valid(a_valid),
    .instr(a_instr), .instr_pc(a_pc), .instr_ready(a_ready)
  );

  if_prefetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut_b (
    .clk(clk), .rst(rst), .imem_en(b_en), .imem_addr(b_addr), .imem_rdata(b_rdata),
    .redirect_valid(b_redir), .redirect_pc(b_redir_pc), .instr_valid(b_valid),
    .instr(b_instr), .instr_pc(b_pc), .instr_ready(b_ready)
  );

  always @(posedge clk) begin
    a_rdata <= a_en ? (a_addr >> 2) : 32'hDEAD_BEEF;
    b_rdata <= b_en ? (b_addr >> 2) : 32'hDEAD_BEEF;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("ok   %s: %h", tag, got);
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    a_ready = 1'b1; a_redir = 1'b0; a_redir_pc = '0;
    b_ready = 1'b1; b_redir = 1'b0; b_redir_pc = '0;
    repeat (2) tick();

    check("rst_valid", a_valid, 0);
    check("rst_en",    a_en,    0);
    check("rst_addr",  a_addr,  0);
    check("rst_instr", a_instr, 0);
    check("rst_pc",    a_pc,    0);
    check("rst_b_addr", b_addr, 32'hFFFF_FFF8);

    // Reset release with ready high: one read per cycle, first delivery two cycles later.
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("t1_en0",   a_en,   1);
    check("t1_addr0", a_addr, 0);
    check("t5_addr0", b_addr, 32'hFFFF_FFF8);
    tick();
    check("t1_addr1",  a_addr,  4);
    check("t1_valid1", a_valid, 0);
    check("t5_addr1",  b_addr,  32'hFFFF_FFFC);
    tick();
    check("t5_addr2",  b_addr,  32'h0000_0000);
    check("t5_valid",  b_valid, 1);
    check("t5_pc",     b_pc,    32'hFFFF_FFF8);
    check("t5_instr",  b_instr, 32'h3FFF_FFFE);
    for (int k = 0; k < 4; k++) begin
      check("t1_valid", a_valid, 1);
      check("t1_pc",    a_pc,    32'(4 * k));
      check("t1_instr", a_instr, 32'(k));
      check("t1_addr",  a_addr,  32'(8 + 4 * k));
      tick();
    end

    // Back-pressure: queue fills to DEPTH then fetch stalls.
    rst = 1'b1;
    a_ready = 1'b0;
    tick();
    @(negedge clk);
    rst = 1'b0;
    repeat (10) tick();
    check("t2_full_valid", a_valid, 1);
    check("t2_full_en",    a_en,    0);
    check("t2_head_pc",    a_pc,    0);
    check("t2_head_instr", a_instr, 0);
    a_ready = 1'b1;
    #1;
    check("t2_resume_en",   a_en,   1);
    check("t2_resume_addr", a_addr, 16);
    for (int k = 0; k < 6; k++) begin
      check("t2_valid", a_valid, 1);
      check("t2_pc",    a_pc,    32'(4 * k));
      check("t2_instr", a_instr, 32'(k));
      tick();
    end

    // Redirect with a read in flight; low address bits are ignored.
    a_redir = 1'b1;
    a_redir_pc = 32'h0000_0103;
    #1;
    check("t3_redir_en", a_en, 0);
    tick();
    a_redir = 1'b0;
    #1;
    check("t3_valid_r1", a_valid, 0);
    check("t3_en_r1",    a_en,    1);
    check("t3_addr_r1",  a_addr,  32'h100);
    tick();
    check("t3_valid_r2", a_valid, 0);
    tick();
    check("t3_valid_r3", a_valid, 1);
    check("t3_pc_r3",    a_pc,    32'h100);
    check("t3_instr_r3", a_instr, 32'h40);
    tick();
    check("t3_pc_r4",    a_pc,    32'h104);
    check("t3_instr_r4", a_instr, 32'h41);

    // Redirect coincident with a pop from a full queue.
    a_ready = 1'b0;
    repeat (8) tick();
    check("t4_full_valid", a_valid, 1);
    check("t4_full_en",    a_en,    0);
    check("t4_head_pc",    a_pc,    32'h104);
    a_ready = 1'b1;
    a_redir = 1'b1;
    a_redir_pc = 32'h0000_0200;
    #1;
    check("t4_redir_en", a_en, 0);
    tick();
    a_redir = 1'b0;
    #1;
    check("t4_valid_r1", a_valid, 0);
    check("t4_en_r1",    a_en,    1);
    check("t4_addr_r1",  a_addr,  32'h200);
    tick();
    check("t4_valid_r2", a_valid, 0);
    tick();
    check("t4_valid_r3", a_valid, 1);
    check("t4_pc_r3",    a_pc,    32'h200);
    check("t4_instr_r3", a_instr, 32'h80);

    // Asynchronous reset with three entries queued.
    rst = 1'b1;
    a_ready = 1'b0;
    tick();
    @(negedge clk);
    rst = 1'b0;
    repeat (4) tick();
    check("t6_pre_valid", a_valid, 1);
    check("t6_pre_pc",    a_pc,    0);
    rst = 1'b1;
    #1;
    check("t6_rst_valid", a_valid, 0);
    check("t6_rst_en",    a_en,    0);
    check("t6_rst_pc",    a_pc,    0);
    check("t6_rst_instr", a_instr, 0);
    check("t6_rst_addr",  a_addr,  0);
    tick();
    @(negedge clk);
    rst = 1'b0;
    a_ready = 1'b1;
    #1;
    check("t6_rel_en",   a_en,   1);
    check("t6_rel_addr", a_addr, 0);
    tick();
    tick();
    check("t6_rel_valid", a_valid, 1);
    check("t6_rel_pc",    a_pc,    0);
    check("t6_rel_instr", a_instr, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
